pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Control end of the pipeline-latch interface. Each cycle it produces the per-latch command (enable / stall / nop) for the fetch-decode, decode-execute, execute-memory and memory-writeback latches, plus the PC write enable.
- Resolves four conditions in a fixed priority order: instruction-fetch miss, data-memory wait, load-use hazard, and control-flow flush.
- Holds a sticky halt state and two saturating performance counters.
- Sits beside the datapath and drives the state field of the shared pipeline interface.

Parameters:
- CNT_W, 16, width of the stall_cycles and flush_count counters.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- ihit  in  1  instruction memory returned the fetch this cycle
- dhit  in  1  data memory completed the MEM-stage access this cycle
- dren_mem  in  1  MEM-stage instruction reads data memory
- dwen_mem  in  1  MEM-stage instruction writes data memory
- brtaken_mem  in  1  branch resolved taken in the MEM stage
- jump_dec  in  1  J/JAL/JR decoded in the decode stage
- halt_mem  in  1  HALT instruction reached the MEM stage
- ld_ex  in  1  EX-stage instruction is a load
- rd_ex  in  5  EX-stage destination register
- rs_dec  in  5  decode-stage source register rs
- rt_dec  in  5  decode-stage source register rt
- fd_state  out  2  fetch-decode latch command (pipe_state_t)
- de_state  out  2  decode-execute latch command
- em_state  out  2  execute-memory latch command
- mw_state  out  2  memory-writeback latch command
- pc_en  out  1  PC register write enable
- halted  out  1  processor halted
- stall_cycles  out  CNT_W  count of cycles with pc_en=0 while not halted
- flush_count  out  CNT_W  count of branch and jump flushes

Behaviour:
- pipe_state_t encoding: PIPE_ENABLE=2'd0, PIPE_STALL=2'd1, PIPE_NOP=2'd2.
  - PIPE_ENABLE: latch loads.
  - PIPE_STALL: latch holds.
  - PIPE_NOP: latch clears to zero.
- FSM states: RUN, DWAIT, HALT.
- Outputs are Mealy, decided in the same cycle from the state and inputs, so the latches act on the next CLK edge. Zero added latency.
- While nRST is low:
  - state=RUN, counters=0, halted=0.
  - All four stage commands are forced to PIPE_NOP and pc_en=0.
- Decision priority, highest first; exactly one row applies each cycle:
  1. HALT state or halt_mem=1: all stages STALL, pc_en=0, halted=1, next state HALT. HALT is left only by reset.
  2. (dren_mem|dwen_mem) & !dhit: fd/de/em STALL, mw NOP (prevents a duplicate writeback), pc_en=0, next state DWAIT.
  3. brtaken_mem: fd/de/em NOP, mw ENABLE, pc_en=1 (redirect; an outstanding fetch is discarded), flush_count+1.
  4. Load-use: ld_ex & rd_ex!=0 & (rd_ex==rs_dec | rd_ex==rt_dec). Result: fd STALL, de NOP, em/mw ENABLE, pc_en=0.
  5. jump_dec: fd NOP, de/em/mw ENABLE, pc_en=1, flush_count+1.
  6. !ihit: fd NOP, de/em/mw ENABLE, pc_en=0.
  7. Otherwise: all ENABLE, pc_en=1.
- DWAIT state:
  - Stays in DWAIT while row 2 holds.
  - On the dhit cycle, returns to RUN and the output is the lower-priority row that applies in that same cycle. Rows 3–7 are evaluated normally.
- Simultaneous events:
  - A load-use hazard together with !ihit resolves to row 4; the fd STALL holds the decode instruction.
  - A jump together with !ihit resolves to row 5; the PC is redirected even though the fetch was a miss.
- Counters:
  - Width CNT_W, saturating at all ones, no wrap.
  - stall_cycles increments on every cycle with pc_en=0 and halted=0, with nRST high.
  - flush_count increments once per row-3 or row-5 cycle.
  - Both are frozen in HALT.
- Reset asserted mid-DWAIT or mid-HALT: immediate return to RUN and counters cleared, asynchronously.

Decomposition:
- Shared package (cpu_types_pkg) holds:
  - pipe_state_t, with PIPE_ENABLE/PIPE_STALL/PIPE_NOP.
  - hzd_state_t, with RUN/DWAIT/HALT.
  - regbits_t, the 5-bit register index type.
- One natural sub-module: hazard_sat_counter. It is a parameterised saturating counter with an increment enable and asynchronous clear, instantiated twice.

Test Plan:
- Reset release, then ihit=1 with no hazards → all four states PIPE_ENABLE, pc_en=1, stall_cycles=0.
- ld_ex=1, rd_ex=5'd8, rt_dec=5'd8 for one cycle → fd=STALL, de=NOP, pc_en=0, stall_cycles=1. Repeating with rd_ex=0 gives all ENABLE.
- dren_mem=1, dhit=0 for 3 cycles, then dhit=1 → 3 cycles with mw=NOP and fd/de/em=STALL. On the dhit cycle all ENABLE and state RUN; stall_cycles=3.
- brtaken_mem=1 and jump_dec=1 in the same cycle → fd/de/em=NOP, mw=ENABLE, pc_en=1, flush_count=1 (not 2).
- halt_mem=1 for one cycle, then 0 → halted stays 1 and all stages STALL indefinitely. Pulsing nRST low returns to RUN with counters 0.
- Force stall_cycles to all ones (CNT_W=4 build, 20 stall cycles) → value stays at 4'hF.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: latch commands, hazard-controller states and the
// register index type.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        PIPE_ENABLE = 2'd0,
        PIPE_STALL  = 2'd1,
        PIPE_NOP    = 2'd2
    } pipe_state_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } hzd_state_t;

    typedef logic [4:0] regbits_t;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter with increment enable and asynchronous active-low clear.
module hazard_sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            r_cnt <= '0;
        else if (i_inc && (r_cnt != '1))
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline-latch control: per-latch enable/stall/nop commands, PC enable,
// sticky halt and stall/flush performance counters.
module pipeline_hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dren_mem,
    input  logic             dwen_mem,
    input  logic             brtaken_mem,
    input  logic             jump_dec,
    input  logic             halt_mem,
    input  logic             ld_ex,
    input  regbits_t         rd_ex,
    input  regbits_t         rs_dec,
    input  regbits_t         rt_dec,
    output pipe_state_t      fd_state,
    output pipe_state_t      de_state,
    output pipe_state_t      em_state,
    output pipe_state_t      mw_state,
    output logic             pc_en,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    hzd_state_t r_state;
    hzd_state_t w_next;
    logic       w_dmiss;
    logic       w_load_use;
    logic       w_flush;
    logic       w_stall_inc;

    assign w_dmiss    = (dren_mem | dwen_mem) & ~dhit;
    assign w_load_use = ld_ex & (rd_ex != '0) & ((rd_ex == rs_dec) | (rd_ex == rt_dec));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            r_state <= RUN;
        else
            r_state <= w_next;
    end

    // DWAIT only differs from RUN in the next-state; on the dhit cycle the
    // lower-priority rows are evaluated exactly as in RUN.
    always_comb begin
        w_next   = RUN;
        fd_state = PIPE_ENABLE;
        de_state = PIPE_ENABLE;
        em_state = PIPE_ENABLE;
        mw_state = PIPE_ENABLE;
        pc_en    = 1'b1;
        halted   = 1'b0;
        w_flush  = 1'b0;
        if (!nRST) begin
            fd_state = PIPE_NOP;
            de_state = PIPE_NOP;
            em_state = PIPE_NOP;
            mw_state = PIPE_NOP;
            pc_en    = 1'b0;
        end else if ((r_state == HALT) || halt_mem) begin
            w_next   = HALT;
            fd_state = PIPE_STALL;
            de_state = PIPE_STALL;
            em_state = PIPE_STALL;
            mw_state = PIPE_STALL;
            pc_en    = 1'b0;
            halted   = 1'b1;
        end else if (w_dmiss) begin
            w_next   = DWAIT;
            fd_state = PIPE_STALL;
            de_state = PIPE_STALL;
            em_state = PIPE_STALL;
            mw_state = PIPE_NOP;
            pc_en    = 1'b0;
        end else if (brtaken_mem) begin
            fd_state = PIPE_NOP;
            de_state = PIPE_NOP;
            em_state = PIPE_NOP;
            w_flush  = 1'b1;
        end else if (w_load_use) begin
            fd_state = PIPE_STALL;
            de_state = PIPE_NOP;
            pc_en    = 1'b0;
        end else if (jump_dec) begin
            fd_state = PIPE_NOP;
            w_flush  = 1'b1;
        end else if (!ihit) begin
            fd_state = PIPE_NOP;
            pc_en    = 1'b0;
        end
        w_stall_inc = nRST & ~pc_en & ~halted;
    end

    hazard_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .i_inc (w_stall_inc),
        .o_cnt (stall_cycles)
    );

    hazard_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .i_inc (w_flush),
        .o_cnt (flush_count)
    );

endmodule
